// File: rtl/data_bus_master_pkg.sv
// Shared encodings for the peripheral data-bus initiator and its lane helper.
package data_bus_master_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam logic [3:0] LANE_B = 4'b0001;
    localparam logic [3:0] LANE_H = 4'b0011;
    localparam logic [3:0] LANE_W = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_e;

    typedef struct packed {
        logic       store;
        logic [1:0] size;
        logic       uns;
        logic [1:0] off;
    } req_t;

endpackage

// File: rtl/data_bus_align.sv
// Combinational byte-lane helper: alignment check, write lanes, load extraction.
module data_bus_align
    import data_bus_master_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        size,
    input  logic [1:0]        off,
    input  logic              uns,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic              misaligned,
    output logic [3:0]        we,
    output logic [DATA_W-1:0] wdata_lane,
    output logic [DATA_W-1:0] rdata_ext
);

    logic [4:0]        shamt;
    logic [DATA_W-1:0] rsh;

    always_comb begin
        shamt      = {off, 3'b000};
        wdata_lane = wdata << shamt;
        rsh        = rdata >> shamt;
        misaligned = 1'b0;
        we         = LANE_W;
        rdata_ext  = rsh;
        case (size)
            SIZE_B: begin
                we        = LANE_B << off;
                rdata_ext = {{(DATA_W-8){~uns & rsh[7]}}, rsh[7:0]};
            end
            SIZE_H: begin
                misaligned = off[0];
                we         = LANE_H << off;
                rdata_ext  = {{(DATA_W-16){~uns & rsh[15]}}, rsh[15:0]};
            end
            SIZE_W: misaligned = |off;
            default: begin
                misaligned = 1'b1;
                we         = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/data_bus_master.sv
// Single-outstanding load/store initiator on the peripheral valid/ready bus,
// with ready timeout and a one-cycle done/err completion pulse.
module data_bus_master
    import data_bus_master_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic              store_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              bus_valid_o,
    input  logic              bus_ready_i,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    output logic [3:0]        bus_we_o,
    input  logic [DATA_W-1:0] bus_rdata_i
);

    localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

    state_e            state;
    req_t              req_q;
    req_t              req_sel;
    logic [7:0]        cnt;
    logic              mis;
    logic [3:0]        lane_we;
    logic [DATA_W-1:0] lane_wdata;
    logic [DATA_W-1:0] rdata_ext;

    // IDLE decodes the live request; afterwards the latched one drives load extraction.
    always_comb begin
        req_sel = req_q;
        if (state == ST_IDLE) begin
            req_sel.store = store_i;
            req_sel.size  = size_i;
            req_sel.uns   = unsigned_i;
            req_sel.off   = addr_i[1:0];
        end
    end

    data_bus_align #(.DATA_W(DATA_W)) u_align (
        .size       (req_sel.size),
        .off        (req_sel.off),
        .uns        (req_sel.uns),
        .wdata      (wdata_i),
        .rdata      (bus_rdata_i),
        .misaligned (mis),
        .we         (lane_we),
        .wdata_lane (lane_wdata),
        .rdata_ext  (rdata_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            req_q       <= '0;
            cnt         <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            rdata_o     <= '0;
            bus_valid_o <= 1'b0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            bus_we_o    <= 4'b0000;
        end else begin
            done_o      <= 1'b0;
            bus_valid_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (req_i) begin
                        req_q  <= req_sel;
                        busy_o <= 1'b1;
                        if (mis) begin
                            state   <= ST_RESP;
                            done_o  <= 1'b1;
                            err_o   <= 1'b1;
                            rdata_o <= '0;
                        end else begin
                            state       <= ST_ISSUE;
                            bus_valid_o <= 1'b1;
                            bus_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
                            bus_wdata_o <= lane_wdata;
                            bus_we_o    <= req_sel.store ? lane_we : 4'b0000;
                        end
                    end
                end
                ST_ISSUE: begin
                    // The issue cycle counts toward the timeout budget.
                    bus_we_o <= 4'b0000;
                    cnt      <= cnt + 8'd1;
                    if (bus_ready_i) begin
                        state   <= ST_RESP;
                        done_o  <= 1'b1;
                        err_o   <= 1'b0;
                        rdata_o <= req_q.store ? '0 : rdata_ext;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt + 8'd1;
                    if (bus_ready_i) begin
                        state   <= ST_RESP;
                        done_o  <= 1'b1;
                        err_o   <= 1'b0;
                        rdata_o <= req_q.store ? '0 : rdata_ext;
                    end else if ((cnt + 8'd1) >= TIMEOUT_W) begin
                        state   <= ST_RESP;
                        done_o  <= 1'b1;
                        err_o   <= 1'b1;
                        rdata_o <= '0;
                    end
                end
                ST_RESP: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                    err_o  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_bus_master.sv
// Randomized bench for data_bus_master with a transaction-timeline reference model.
module tb_data_bus_master;

    localparam int TO   = 4;
    localparam int MAXC = 8000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_i = 1'b0, store_i = 1'b0, unsigned_i = 1'b0;
    logic [1:0]  size_i = 2'd0;
    logic [31:0] addr_i = '0, wdata_i = '0, bus_rdata_i = '0;
    logic        bus_ready_i = 1'b0;
    logic        busy_o, done_o, err_o, bus_valid_o;
    logic [31:0] rdata_o, bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_we_o;

    always #5 clk = ~clk;

    data_bus_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .store_i(store_i), .size_i(size_i),
        .unsigned_i(unsigned_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
        .bus_valid_o(bus_valid_o), .bus_ready_i(bus_ready_i), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_we_o(bus_we_o), .bus_rdata_i(bus_rdata_i)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected per-cycle timeline; held outputs change only on the listed events.
    bit        e_busy[MAXC], e_valid[MAXC], e_done[MAXC], e_err[MAXC];
    bit [3:0]  e_we[MAXC];
    bit        ev_rst[MAXC], ev_addr[MAXC], ev_rd[MAXC];
    bit [31:0] v_addr[MAXC], v_wdata[MAXC], v_rd[MAXC];
    bit [31:0] h_addr = '0, h_wdata = '0, h_rd = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic bit model_mis(input bit [1:0] sz, input bit [1:0] a);
        int unsigned align = 32'd1 << sz;
        return (sz == 2'd3) || ((int'(a) % align) != 0);
    endfunction

    function automatic bit [3:0] model_we(input bit [1:0] sz, input bit [1:0] a);
        int unsigned w;
        if (sz == 2'd2) w = 15;
        else w = ((sz == 2'd0) ? 1 : 3) * (32'd1 << a);
        return 4'(w);
    endfunction

    function automatic bit [31:0] model_wdata(input bit [31:0] wd, input bit [1:0] a);
        return wd << (8 * a);
    endfunction

    function automatic bit [31:0] model_load(input bit [31:0] w, input bit [1:0] sz,
                                             input bit [1:0] a, input bit un);
        int unsigned v, bits;
        bits = (sz == 2'd0) ? 8 : (sz == 2'd1) ? 16 : 32;
        v = w >> (8 * a);
        if (bits < 32) begin
            v = v % (32'd1 << bits);
            if (!un && v >= (32'd1 << (bits - 1))) v = v - (32'd1 << bits);
        end
        return v;
    endfunction

    // Cycles from the request cycle to the done pulse.
    function automatic int model_done_off(input bit mis, input int d);
        if (mis) return 1;
        return (d < TO) ? 2 + d : 1 + TO;
    endfunction

    always @(negedge clk) begin
        if (cyc >= 1 && cyc < MAXC) begin
            if (ev_rst[cyc]) begin h_addr = '0; h_wdata = '0; h_rd = '0; end
            if (ev_addr[cyc]) begin h_addr = v_addr[cyc]; h_wdata = v_wdata[cyc]; end
            if (ev_rd[cyc]) h_rd = v_rd[cyc];
            chk("busy",      32'(busy_o),      32'(e_busy[cyc]));
            chk("done",      32'(done_o),      32'(e_done[cyc]));
            chk("err",       32'(err_o),       32'(e_err[cyc]));
            chk("rdata",     rdata_o,          h_rd);
            chk("bus_valid", 32'(bus_valid_o), 32'(e_valid[cyc]));
            chk("bus_we",    32'(bus_we_o),    32'(e_we[cyc]));
            chk("bus_addr",  bus_addr_o,       h_addr);
            chk("bus_wdata", bus_wdata_o,      h_wdata);
        end
    end

    // d: cycles after the valid cycle that ready rises (>= TO means never).
    // rk: if nonzero, rst is raised rk cycles after the request (timeout txns only).
    task automatic run_txn(input bit st, input bit [1:0] sz, input bit un, input bit [31:0] ad,
                           input bit [31:0] wd, input bit [31:0] rw, input int d, input int rk);
        int n, dn, last, rkk;
        bit [1:0] a;
        bit mis, tmo;
        @(posedge clk); #1;
        n   = cyc;
        a   = ad[1:0];
        mis = model_mis(sz, a);
        tmo = !mis && d >= TO;
        dn  = n + model_done_off(mis, d);
        rkk = (!tmo || rk >= dn - n) ? 0 : rk;
        last = (rkk > 0) ? n + rkk + 1 : dn;
        req_i = 1'b1; store_i = st; size_i = sz; unsigned_i = un;
        addr_i = ad; wdata_i = wd;
        bus_ready_i = 1'($urandom_range(0, 1));
        bus_rdata_i = $urandom;
        for (int c = n + 1; c <= ((rkk > 0) ? n + rkk : dn); c++) e_busy[c] = 1'b1;
        if (!mis) begin
            e_valid[n+1] = 1'b1;
            e_we[n+1]    = st ? model_we(sz, a) : 4'b0000;
            ev_addr[n+1] = 1'b1;
            v_addr[n+1]  = ad & 32'hFFFF_FFFC;
            v_wdata[n+1] = model_wdata(wd, a);
        end
        if (rkk > 0) begin
            ev_rst[n+rkk+1] = 1'b1;
        end else begin
            e_done[dn] = 1'b1;
            e_err[dn]  = mis || tmo;
            ev_rd[dn]  = 1'b1;
            v_rd[dn]   = (mis || tmo || st) ? 32'h0 : model_load(rw, sz, a, un);
        end
        for (int c = n + 1; c <= last; c++) begin
            @(posedge clk); #1;
            req_i      = 1'($urandom_range(0, 1));
            store_i    = 1'($urandom_range(0, 1));
            size_i     = 2'($urandom_range(0, 3));
            unsigned_i = 1'($urandom_range(0, 1));
            addr_i     = $urandom;
            wdata_i    = $urandom;
            rst        = (rkk > 0 && c == n + rkk);
            if (c == dn) bus_ready_i = tmo ? 1'b1 : 1'($urandom_range(0, 1));
            else bus_ready_i = !mis && !tmo && (c == n + 1 + d);
            bus_rdata_i = (c == n + 1 + d) ? rw : $urandom;
            if (rkk > 0 && c == n + rkk + 1) req_i = 1'b0;
        end
    endtask

    task automatic idle_cyc();
        @(posedge clk); #1;
        req_i       = 1'b0;
        bus_ready_i = 1'($urandom_range(0, 1));
        bus_rdata_i = $urandom;
        addr_i      = $urandom;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Pin the model against hand-computed values.
        chk("lit_half_signed",   model_load(32'h8001_1234, 2'd1, 2'd2, 1'b0), 32'hFFFF_8001);
        chk("lit_half_unsigned", model_load(32'h8001_1234, 2'd1, 2'd2, 1'b1), 32'h0000_8001);
        chk("lit_byte_signed",   model_load(32'h8001_1234, 2'd0, 2'd1, 1'b0), 32'h0000_0012);
        chk("lit_we_byte3",      32'(model_we(2'd0, 2'd3)), 32'h8);
        chk("lit_we_half2",      32'(model_we(2'd1, 2'd2)), 32'hC);
        chk("lit_wdata_byte3",   model_wdata(32'h0000_00A5, 2'd3), 32'hA500_0000);
        chk("lit_mis_half1",     32'(model_mis(2'd1, 2'd1)), 32'd1);
        chk("lit_mis_word2",     32'(model_mis(2'd2, 2'd2)), 32'd1);
        chk("lit_mis_byte3",     32'(model_mis(2'd0, 2'd3)), 32'd0);
        chk("lit_lat_ready1",    32'(model_done_off(1'b0, 1)), 32'd3);
        chk("lit_lat_mis",       32'(model_done_off(1'b1, 0)), 32'd1);
        chk("lit_lat_timeout",   32'(model_done_off(1'b0, 99)), 32'd5);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle_cyc();

        run_txn(1'b1, 2'd2, 1'b0, 32'h1004, 32'hDEADBEEF, $urandom, 1, 0);
        run_txn(1'b1, 2'd0, 1'b0, 32'h1003, 32'h0000_00A5, $urandom, 1, 0);
        run_txn(1'b0, 2'd1, 1'b0, 32'h1002, $urandom, 32'h8001_1234, 1, 0);
        run_txn(1'b0, 2'd1, 1'b1, 32'h1002, $urandom, 32'h8001_1234, 1, 0);
        run_txn(1'b0, 2'd0, 1'b0, 32'h1001, $urandom, 32'h8001_1234, 1, 0);
        run_txn(1'b0, 2'd1, 1'b0, 32'h1001, $urandom, $urandom, 1, 0);
        run_txn(1'b1, 2'd2, 1'b0, 32'h1002, $urandom, $urandom, 1, 0);
        run_txn(1'b0, 2'd3, 1'b0, 32'h1000, $urandom, $urandom, 1, 0);
        run_txn(1'b0, 2'd2, 1'b0, 32'h2000, $urandom, $urandom, TO + 3, 0);
        run_txn(1'b0, 2'd2, 1'b0, 32'h3000, $urandom, 32'hCAFE_F00D, TO - 1, 0);
        run_txn(1'b0, 2'd0, 1'b0, 32'h3003, $urandom, 32'h80FF_FFFF, 0, 0);
        idle_cyc();
        run_txn(1'b0, 2'd2, 1'b0, 32'h4000, $urandom, $urandom, 99, 3);
        run_txn(1'b0, 2'd2, 1'b0, 32'h4004, $urandom, 32'h1234_5678, 1, 0);

        for (int i = 0; i < 300 && cyc < MAXC - 40; i++) begin
            if ($urandom_range(0, 19) == 0)
                run_txn(1'b0, 2'($urandom_range(0, 2)), 1'b0, $urandom & 32'hFFFF_FFFC,
                        $urandom, $urandom, 99, $urandom_range(1, TO));
            else
                run_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                        1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                        $urandom_range(0, TO + 1), 0);
            repeat ($urandom_range(0, 2)) idle_cyc();
        end
        repeat (3) idle_cyc();
        @(posedge clk); #2;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
